// File: rtl/puf_resp_framer_if.sv
// puf_resp_framer_if: capture-side and UART-side signals of the PUF response framer.
// Latency: none, this is wiring only.
// Backpressure: the UART side paces the frame through the tx_DV / tx_done byte handshake.
// Ports / signals:
//   response, response_DV, challenge : word capture (response_DV is a one-cycle strobe)
//   tx_byte, tx_DV, tx_done          : byte handshake towards the UART transmitter
//   busy, frame_done, overrun, timeout_err : framer status
// modport master is taken by the framer; modport slave is taken by its environment.
interface puf_resp_framer_if #(
  parameter int RESP_BYTES = 32
);
  logic [8*RESP_BYTES-1:0] response;
  logic                    response_DV;
  logic [7:0]              challenge;
  logic                    tx_done;
  logic [7:0]              tx_byte;
  logic                    tx_DV;
  logic                    busy;
  logic                    frame_done;
  logic                    overrun;
  logic                    timeout_err;

  modport master (
    input  response, response_DV, challenge, tx_done,
    output tx_byte, tx_DV, busy, frame_done, overrun, timeout_err
  );

  modport slave (
    output response, response_DV, challenge, tx_done,
    input  tx_byte, tx_DV, busy, frame_done, overrun, timeout_err
  );
endinterface

// File: rtl/puf_resp_framer.sv
// puf_resp_framer: serialises one captured 256-bit response into HEADER, challenge, response bytes (MSB first), checksum.
// Latency: the first tx_DV follows the capture edge by one cycle; each later tx_DV follows its tx_done by one cycle.
// Backpressure: one byte in flight; waits for tx_done, and a watchdog aborts the frame if tx_done never comes.
// Ports:
//   clk, reset_n : system clock, synchronous active-low reset
//   bus          : puf_resp_framer_if.master (capture inputs, UART byte handshake, status outputs)
// Build option: define FRAMER_CRC8_EN to send CRC-8 (poly 0x07, init 0x00) instead of the XOR checksum.
// TIMEOUT must be at least 2.
module puf_resp_framer #(
  parameter int          RESP_BYTES = 32,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int          TIMEOUT    = 20000
) (
  input  logic               clk,
  input  logic               reset_n,
  puf_resp_framer_if.master  bus
);

  localparam int RW        = 8 * RESP_BYTES;
  localparam int FRAME_LEN = RESP_BYTES + 3;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam int WW        = $clog2(TIMEOUT + 1);

  // Frame byte indices: 0 header, 1 challenge, 2..RESP_BYTES+1 response, last checksum.
  localparam logic [CW-1:0] IDX_CHAL      = CW'(1);
  localparam logic [CW-1:0] IDX_RESP_FIRST = CW'(2);
  localparam logic [CW-1:0] IDX_RESP_LAST  = CW'(RESP_BYTES + 1);
  localparam logic [CW-1:0] IDX_LAST       = CW'(FRAME_LEN - 1);

  localparam logic [WW-1:0] WDOG_LOAD = WW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,       state_d;
  logic [RW-1:0] resp_sr_q,     resp_sr_d;
  logic [7:0]    chal_q,        chal_d;
  logic [CW-1:0] cnt_q,         cnt_d;
  logic [7:0]    chk_q,         chk_d;
  logic [WW-1:0] wdog_q,        wdog_d;
  logic [7:0]    tx_byte_q,     tx_byte_d;
  logic          overrun_q,     overrun_d;
  logic          timeout_err_q, timeout_err_d;

  logic [CW-1:0] nxt_idx;

  // Accumulate one transmitted byte into the running checksum.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
`ifdef FRAMER_CRC8_EN
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
`else
    c = acc ^ b;
`endif
    return c;
  endfunction

  always_comb begin
    state_d       = state_q;
    resp_sr_d     = resp_sr_q;
    chal_d        = chal_q;
    cnt_d         = cnt_q;
    chk_d         = chk_q;
    wdog_d        = wdog_q;
    tx_byte_d     = tx_byte_q;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;
    nxt_idx       = cnt_q + CW'(1);

    // Only IDLE accepts a word; anything else (including the DONE cycle) drops it.
    if (bus.response_DV && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.response_DV) begin
          resp_sr_d     = bus.response;
          chal_d        = bus.challenge;
          cnt_d         = '0;
          chk_d         = '0;
          tx_byte_d     = HEADER;
          // Watchdog starts counting in the strobe cycle itself, so the abort
          // lands TIMEOUT cycles after tx_DV.
          wdog_d        = WDOG_LOAD;
          timeout_err_d = 1'b0;
          state_d       = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wdog_d = wdog_q - WW'(1);
        // Checksum covers challenge and response bytes, one byte per strobe.
        if ((cnt_q != '0) && (cnt_q != IDX_LAST)) begin
          chk_d = chk_fold(chk_q, tx_byte_q);
        end
        // Response byte just issued leaves the top of the shift register.
        if ((cnt_q >= IDX_RESP_FIRST) && (cnt_q <= IDX_RESP_LAST)) begin
          resp_sr_d = resp_sr_q << 8;
        end
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.tx_done) begin
          if (cnt_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d  = nxt_idx;
            wdog_d = WDOG_LOAD;
            if (nxt_idx == IDX_CHAL) begin
              tx_byte_d = chal_q;
            end else if (nxt_idx == IDX_LAST) begin
              tx_byte_d = chk_q;
            end else begin
              tx_byte_d = resp_sr_q[RW-1 -: 8];
            end
            state_d = S_ISSUE;
          end
        end else if (wdog_q <= WW'(1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wdog_d = wdog_q - WW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      resp_sr_q     <= '0;
      chal_q        <= '0;
      cnt_q         <= '0;
      chk_q         <= '0;
      wdog_q        <= '0;
      tx_byte_q     <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_sr_q     <= resp_sr_d;
      chal_q        <= chal_d;
      cnt_q         <= cnt_d;
      chk_q         <= chk_d;
      wdog_q        <= wdog_d;
      tx_byte_q     <= tx_byte_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_DV       = (state_q == S_ISSUE);
  assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.frame_done  = (state_q == S_DONE);
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
